// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - shared types and constants for the PC sequencer
//
// Purpose : FSM state enum, instruction class enum, PC source select codes,
//           exception cause codes and exception vector addresses.
// Ports   : none (package).
package pc_seq_pkg;

  typedef enum logic [2:0] {
    ST_FETCH    = 3'd0,
    ST_DECODE   = 3'd1,
    ST_RESOLVE  = 3'd2,
    ST_EXC_SAVE = 3'd3,
    ST_EXC_VEC  = 3'd4,
    ST_EXC_LOAD = 3'd5
  } pc_state_t;

  typedef enum logic [2:0] {
    IC_SEQ  = 3'd0,
    IC_BEQ  = 3'd1,
    IC_BNE  = 3'd2,
    IC_BLE  = 3'd3,
    IC_BGT  = 3'd4,
    IC_JUMP = 3'd5,
    IC_RTE  = 3'd6,
    IC_RSVD = 3'd7
  } instr_class_t;

  localparam logic [2:0] SEL_PC4    = 3'b000;
  localparam logic [2:0] SEL_BRANCH = 3'b001;
  localparam logic [2:0] SEL_JUMP   = 3'b010;
  localparam logic [2:0] SEL_EPC    = 3'b011;
  localparam logic [2:0] SEL_VECTOR = 3'b100;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_OVF  = 2'b01;
  localparam logic [1:0] CAUSE_INV  = 2'b10;
  localparam logic [1:0] CAUSE_DIV0 = 2'b11;

  localparam logic [31:0] VEC_INV  = 32'd253;
  localparam logic [31:0] VEC_OVF  = 32'd254;
  localparam logic [31:0] VEC_DIV0 = 32'd255;

  function automatic logic [31:0] vec_addr_of(input logic [1:0] cause);
    case (cause)
      CAUSE_OVF:  return VEC_OVF;
      CAUSE_INV:  return VEC_INV;
      CAUSE_DIV0: return VEC_DIV0;
      default:    return 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/pc_branch_cond.sv
// rtl/pc_branch_cond.sv - conditional branch resolution
//
// Purpose : combinational taken flag for the four conditional branch classes.
// Ports   : instr_class in 3  - instruction class
//           alu_zero    in 1  - ALU zero flag
//           alu_gt      in 1  - ALU greater-than flag (A>B)
//           taken       out 1 - conditional branch is taken (0 for non-branches)
module pc_branch_cond
  import pc_seq_pkg::*;
(
  input  logic [2:0] instr_class,
  input  logic       alu_zero,
  input  logic       alu_gt,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (instr_class)
      IC_BEQ:  taken = alu_zero;
      IC_BNE:  taken = ~alu_zero;
      IC_BLE:  taken = ~alu_gt;
      IC_BGT:  taken = alu_gt;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - multicycle PC control FSM with exception sequencing
//
// Purpose : steps FETCH -> DECODE -> RESOLVE, resolves branches/jumps/RTE and
//           runs the EXC_SAVE -> EXC_VEC -> EXC_LOAD exception sequence.
// Ports   : clk, reset_n          - clock, async active-low reset
//           mem_ready             - memory access completes this cycle
//           instr_valid           - decoder class valid (DECODE)
//           instr_class[2:0]      - instruction class
//           alu_zero, alu_gt      - ALU flags
//           exc_req[1:0]          - exception request
//           pcsrc_sel[2:0]        - PC source select
//           pc_write, epc_write   - PC / EPC load enables
//           vec_read, vec_addr    - exception vector read request/address
//           exc_cause[1:0]        - cause of last accepted exception
//           state[2:0]            - current FSM state
module pc_sequencer
  import pc_seq_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_ready,
  input  logic        instr_valid,
  input  logic [2:0]  instr_class,
  input  logic        alu_zero,
  input  logic        alu_gt,
  input  logic [1:0]  exc_req,
  output logic [2:0]  pcsrc_sel,
  output logic        pc_write,
  output logic        epc_write,
  output logic        vec_read,
  output logic [31:0] vec_addr,
  output logic [1:0]  exc_cause,
  output logic [2:0]  state
);

  pc_state_t    cur;
  instr_class_t class_q;
  logic         load_q;
  logic         taken;
  logic         resolve_write;
  logic [2:0]   resolve_sel;

  // Class is captured when DECODE accepts it; flags are read live in RESOLVE,
  // the cycle in which the ALU compare result is available.
  pc_branch_cond u_branch_cond (
    .instr_class (class_q),
    .alu_zero    (alu_zero),
    .alu_gt      (alu_gt),
    .taken       (taken)
  );

  always_comb begin
    resolve_write = 1'b0;
    resolve_sel   = SEL_PC4;
    if (taken) begin
      resolve_write = 1'b1;
      resolve_sel   = SEL_BRANCH;
    end else if (class_q == IC_JUMP) begin
      resolve_write = 1'b1;
      resolve_sel   = SEL_JUMP;
    end else if (class_q == IC_RTE) begin
      resolve_write = 1'b1;
      resolve_sel   = SEL_EPC;
    end
    // A late exception in RESOLVE must not commit the branch.
    if (exc_req != CAUSE_NONE) begin
      resolve_write = 1'b0;
      resolve_sel   = SEL_PC4;
    end
  end

  // EXC_LOAD drives from registers; FETCH and RESOLVE need same-cycle inputs.
  // reset_n gates the FETCH term so a high mem_ready cannot leak through
  // while reset is held.
  always_comb begin
    pc_write  = load_q;
    pcsrc_sel = load_q ? SEL_VECTOR : SEL_PC4;
    case (cur)
      ST_FETCH:   pc_write = mem_ready & reset_n;
      ST_RESOLVE: begin
        pc_write  = resolve_write;
        pcsrc_sel = resolve_sel;
      end
      default: ;
    endcase
  end

  assign state = cur;

  // Registered Moore outputs are loaded with the value for the state being
  // entered, so they are valid throughout that state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur       <= ST_FETCH;
      class_q   <= IC_SEQ;
      exc_cause <= CAUSE_NONE;
      epc_write <= 1'b0;
      vec_read  <= 1'b0;
      vec_addr  <= 32'd0;
      load_q    <= 1'b0;
    end else begin
      epc_write <= 1'b0;
      vec_read  <= 1'b0;
      vec_addr  <= 32'd0;
      load_q    <= 1'b0;
      case (cur)
        ST_FETCH: begin
          if (mem_ready) cur <= ST_DECODE;
        end
        ST_DECODE: begin
          if (instr_valid) begin
            class_q <= instr_class_t'(instr_class);
            if (exc_req != CAUSE_NONE || instr_class == IC_RSVD) begin
              cur       <= ST_EXC_SAVE;
              exc_cause <= (exc_req != CAUSE_NONE) ? exc_req : CAUSE_INV;
              epc_write <= 1'b1;
            end else begin
              cur <= ST_RESOLVE;
            end
          end
        end
        ST_RESOLVE: begin
          if (exc_req != CAUSE_NONE) begin
            cur       <= ST_EXC_SAVE;
            exc_cause <= exc_req;
            epc_write <= 1'b1;
          end else begin
            cur <= ST_FETCH;
          end
        end
        ST_EXC_SAVE: begin
          cur      <= ST_EXC_VEC;
          vec_read <= 1'b1;
          vec_addr <= vec_addr_of(exc_cause);
        end
        ST_EXC_VEC: begin
          if (mem_ready) begin
            cur    <= ST_EXC_LOAD;
            load_q <= 1'b1;
          end else begin
            vec_read <= 1'b1;
            vec_addr <= vec_addr;
          end
        end
        ST_EXC_LOAD: begin
          cur <= ST_FETCH;
        end
        default: begin
          cur <= ST_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer
module tb_pc_sequencer;

  localparam logic [2:0] S_FETCH = 3'd0;
  localparam logic [2:0] S_DEC   = 3'd1;
  localparam logic [2:0] S_RES   = 3'd2;
  localparam logic [2:0] S_SAVE  = 3'd3;
  localparam logic [2:0] S_VEC   = 3'd4;
  localparam logic [2:0] S_LOAD  = 3'd5;

  logic        clk;
  logic        reset_n;
  logic        mem_ready;
  logic        instr_valid;
  logic [2:0]  instr_class;
  logic        alu_zero;
  logic        alu_gt;
  logic [1:0]  exc_req;
  logic [2:0]  pcsrc_sel;
  logic        pc_write;
  logic        epc_write;
  logic        vec_read;
  logic [31:0] vec_addr;
  logic [1:0]  exc_cause;
  logic [2:0]  state;

  int total = 0;
  int bad   = 0;

  logic [8:0]  sq[$];
  logic [42:0] eq[$];
  logic [1:0]  m_cause;

  logic [42:0] obs;
  assign obs = {state, pc_write, pcsrc_sel, epc_write, vec_read, exc_cause, vec_addr};

  pc_sequencer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .mem_ready   (mem_ready),
    .instr_valid (instr_valid),
    .instr_class (instr_class),
    .alu_zero    (alu_zero),
    .alu_gt      (alu_gt),
    .exc_req     (exc_req),
    .pcsrc_sel   (pcsrc_sel),
    .pc_write    (pc_write),
    .epc_write   (epc_write),
    .vec_read    (vec_read),
    .vec_addr    (vec_addr),
    .exc_cause   (exc_cause),
    .state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [42:0] ev(input logic [2:0] st, input logic pcw, input logic [2:0] sel,
                                     input logic epc, input logic vr, input logic [1:0] cause,
                                     input logic [31:0] va);
    return {st, pcw, sel, epc, vr, cause, va};
  endfunction

  // Builds the stimulus and expected-output trace of one instruction, starting
  // and ending in FETCH. junk is driven on exc_req wherever it must be ignored.
  task automatic model_instr(input logic [2:0] cls, input logic z, input logic g,
                             input int fw, input int dw, input logic [1:0] ed,
                             input logic [1:0] er, input int vw, input logic [1:0] junk);
    logic        pcw;
    logic [2:0]  sel;
    logic [1:0]  c;
    logic [31:0] va;
    for (int i = 0; i < fw; i++) begin
      sq.push_back({1'b0, 1'b0, cls, z, g, junk});
      eq.push_back(ev(S_FETCH, 1'b0, 3'd0, 1'b0, 1'b0, m_cause, 32'd0));
    end
    sq.push_back({1'b1, 1'b0, cls, z, g, junk});
    eq.push_back(ev(S_FETCH, 1'b1, 3'd0, 1'b0, 1'b0, m_cause, 32'd0));
    for (int i = 0; i < dw; i++) begin
      sq.push_back({1'b0, 1'b0, cls, z, g, junk});
      eq.push_back(ev(S_DEC, 1'b0, 3'd0, 1'b0, 1'b0, m_cause, 32'd0));
    end
    sq.push_back({1'b0, 1'b1, cls, z, g, ed});
    eq.push_back(ev(S_DEC, 1'b0, 3'd0, 1'b0, 1'b0, m_cause, 32'd0));
    c = 2'b00;
    if (ed != 2'b00) c = ed;
    else if (cls == 3'd7) c = 2'b10;
    else begin
      sq.push_back({1'b0, 1'b0, cls, z, g, er});
      case (cls)
        3'd1: pcw = z;
        3'd2: pcw = ~z;
        3'd3: pcw = ~g;
        3'd4: pcw = g;
        3'd5, 3'd6: pcw = 1'b1;
        default: pcw = 1'b0;
      endcase
      if (er != 2'b00) pcw = 1'b0;
      if (!pcw) sel = 3'd0;
      else if (cls == 3'd5) sel = 3'd2;
      else if (cls == 3'd6) sel = 3'd3;
      else sel = 3'd1;
      eq.push_back(ev(S_RES, pcw, sel, 1'b0, 1'b0, m_cause, 32'd0));
      c = er;
    end
    if (c != 2'b00) begin
      m_cause = c;
      case (c)
        2'b01:   va = 32'd254;
        2'b10:   va = 32'd253;
        default: va = 32'd255;
      endcase
      sq.push_back({junk[0], 1'b0, cls, z, g, junk});
      eq.push_back(ev(S_SAVE, 1'b0, 3'd0, 1'b1, 1'b0, c, 32'd0));
      for (int i = 0; i < vw; i++) begin
        sq.push_back({1'b0, 1'b0, cls, z, g, junk});
        eq.push_back(ev(S_VEC, 1'b0, 3'd0, 1'b0, 1'b1, c, va));
      end
      sq.push_back({1'b1, 1'b0, cls, z, g, junk});
      eq.push_back(ev(S_VEC, 1'b0, 3'd0, 1'b0, 1'b1, c, va));
      sq.push_back({1'b0, 1'b0, cls, z, g, junk});
      eq.push_back(ev(S_LOAD, 1'b1, 3'd4, 1'b0, 1'b0, c, 32'd0));
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; mem_ready = 1'b1; instr_valid = 1'b1;
    instr_class = 3'd5; alu_zero = 1'b1; alu_gt = 1'b1; exc_req = 2'b11;
    m_cause = 2'b00;
    #3;
    total++;
    if (obs !== ev(S_FETCH, 1'b0, 3'd0, 1'b0, 1'b0, 2'b00, 32'd0)) begin
      bad++; $display("FAIL reset_async got=%h want=%h", obs, ev(S_FETCH, 1'b0, 3'd0, 1'b0, 1'b0, 2'b00, 32'd0));
    end
    @(posedge clk); @(negedge clk);
    total++;
    if (obs !== ev(S_FETCH, 1'b0, 3'd0, 1'b0, 1'b0, 2'b00, 32'd0)) begin
      bad++; $display("FAIL reset_held got=%h want=%h", obs, ev(S_FETCH, 1'b0, 3'd0, 1'b0, 1'b0, 2'b00, 32'd0));
    end
    mem_ready = 1'b0; instr_valid = 1'b0; exc_req = 2'b00;
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_seq();
    model_instr(3'd0, 1'b0, 1'b0, 0, 0, 2'b00, 2'b00, 0, 2'b00);
    sq.push_back(9'd0);
    eq.push_back(ev(S_FETCH, 1'b0, 3'd0, 1'b0, 1'b0, m_cause, 32'd0));
    foreach (sq[i]) begin
      {mem_ready, instr_valid, instr_class, alu_zero, alu_gt, exc_req} = sq[i];
      @(negedge clk);
      total++;
      if (obs !== eq[i]) begin bad++; $display("FAIL seq cyc=%0d got=%h want=%h", i, obs, eq[i]); end
      @(posedge clk); #1;
    end
    sq.delete(); eq.delete();
  endtask

  task automatic test_branches();
    model_instr(3'd1, 1'b1, 1'b0, 1, 0, 2'b00, 2'b00, 0, 2'b00);
    model_instr(3'd1, 1'b0, 1'b1, 0, 1, 2'b00, 2'b00, 0, 2'b00);
    model_instr(3'd4, 1'b0, 1'b1, 0, 0, 2'b00, 2'b00, 0, 2'b00);
    model_instr(3'd4, 1'b0, 1'b0, 0, 0, 2'b00, 2'b00, 0, 2'b00);
    model_instr(3'd2, 1'b0, 1'b0, 0, 0, 2'b00, 2'b00, 0, 2'b00);
    model_instr(3'd3, 1'b1, 1'b1, 0, 0, 2'b00, 2'b00, 0, 2'b00);
    model_instr(3'd3, 1'b1, 1'b0, 0, 0, 2'b00, 2'b00, 0, 2'b00);
    foreach (sq[i]) begin
      {mem_ready, instr_valid, instr_class, alu_zero, alu_gt, exc_req} = sq[i];
      @(negedge clk);
      total++;
      if (obs !== eq[i]) begin bad++; $display("FAIL branch cyc=%0d got=%h want=%h", i, obs, eq[i]); end
      @(posedge clk); #1;
    end
    sq.delete(); eq.delete();
  endtask

  task automatic test_jump_rte();
    model_instr(3'd5, 1'b0, 1'b0, 0, 0, 2'b00, 2'b00, 0, 2'b00);
    model_instr(3'd6, 1'b1, 1'b1, 0, 0, 2'b00, 2'b00, 0, 2'b00);
    foreach (sq[i]) begin
      {mem_ready, instr_valid, instr_class, alu_zero, alu_gt, exc_req} = sq[i];
      @(negedge clk);
      total++;
      if (obs !== eq[i]) begin bad++; $display("FAIL jump_rte cyc=%0d got=%h want=%h", i, obs, eq[i]); end
      @(posedge clk); #1;
    end
    sq.delete(); eq.delete();
  endtask

  task automatic test_exc_resolve();
    model_instr(3'd2, 1'b0, 1'b0, 0, 0, 2'b00, 2'b01, 3, 2'b10);
    model_instr(3'd5, 1'b0, 1'b0, 1, 0, 2'b00, 2'b11, 1, 2'b01);
    foreach (sq[i]) begin
      {mem_ready, instr_valid, instr_class, alu_zero, alu_gt, exc_req} = sq[i];
      @(negedge clk);
      total++;
      if (obs !== eq[i]) begin bad++; $display("FAIL exc_resolve cyc=%0d got=%h want=%h", i, obs, eq[i]); end
      @(posedge clk); #1;
    end
    sq.delete(); eq.delete();
  endtask

  task automatic test_invalid();
    model_instr(3'd7, 1'b0, 1'b0, 1, 1, 2'b00, 2'b00, 2, 2'b11);
    foreach (sq[i]) begin
      {mem_ready, instr_valid, instr_class, alu_zero, alu_gt, exc_req} = sq[i];
      @(negedge clk);
      total++;
      if (obs !== eq[i]) begin bad++; $display("FAIL invalid cyc=%0d got=%h want=%h", i, obs, eq[i]); end
      @(posedge clk); #1;
    end
    sq.delete(); eq.delete();
  endtask

  task automatic test_reset_mid_exc();
    mem_ready = 1'b1; instr_valid = 1'b0; instr_class = 3'd7; exc_req = 2'b00;
    @(posedge clk); #1;
    mem_ready = 1'b0; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (obs !== ev(S_VEC, 1'b0, 3'd0, 1'b0, 1'b1, 2'b10, 32'd253)) begin
      bad++; $display("FAIL mid_exc_vec got=%h want=%h", obs, ev(S_VEC, 1'b0, 3'd0, 1'b0, 1'b1, 2'b10, 32'd253));
    end
    #1;
    reset_n = 1'b0; mem_ready = 1'b1;
    #1;
    total++;
    if (obs !== ev(S_FETCH, 1'b0, 3'd0, 1'b0, 1'b0, 2'b00, 32'd0)) begin
      bad++; $display("FAIL mid_exc_reset got=%h want=%h", obs, ev(S_FETCH, 1'b0, 3'd0, 1'b0, 1'b0, 2'b00, 32'd0));
    end
    mem_ready = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    m_cause = 2'b00;
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (obs !== ev(S_FETCH, 1'b0, 3'd0, 1'b0, 1'b0, 2'b00, 32'd0)) begin
      bad++; $display("FAIL mid_exc_release got=%h want=%h", obs, ev(S_FETCH, 1'b0, 3'd0, 1'b0, 1'b0, 2'b00, 32'd0));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [1:0] ed;
    logic [1:0] er;
    for (int n = 0; n < 60; n++) begin
      ed = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      er = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      model_instr(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), ed, er,
                  int'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    end
    foreach (sq[i]) begin
      {mem_ready, instr_valid, instr_class, alu_zero, alu_gt, exc_req} = sq[i];
      @(negedge clk);
      total++;
      if (obs !== eq[i]) begin bad++; $display("FAIL random cyc=%0d got=%h want=%h", i, obs, eq[i]); end
      @(posedge clk); #1;
    end
    sq.delete(); eq.delete();
  endtask

  initial begin
    test_reset();
    test_seq();
    test_branches();
    test_jump_rte();
    test_exc_resolve();
    test_invalid();
    test_reset_mid_exc();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-low reset.
REQ-002 clk  in  1  system clock; all state updates on the rising edge.
REQ-003 reset_n  in  1  asynchronous active-low reset.
REQ-004 mem_ready  in  1  memory access completes this cycle (fetch or vector read).
REQ-005 instr_valid  in  1  decoder class is valid this cycle.
REQ-006 instr_class  in  3  instruction class: 0 SEQ, 1 BEQ, 2 BNE, 3 BLE, 4 BGT, 5 JUMP, 6 RTE, 7 reserved.
REQ-007 alu_zero  in  1  ALU zero flag; alu_gt  in  1  ALU greater-than flag (A>B).
REQ-008 exc_req  in  2  exception request: 00 none, 01 overflow, 10 invalid opcode, 11 divide by zero.
REQ-009 pcsrc_sel  out  3  PC source select: 000 ALU result (PC+4), 001 ALUOut (branch target), 010 jump target, 011 EPC, 100 exception vector loaded from memory.
REQ-010 pc_write  out  1  PC register load enable.
REQ-011 epc_write  out  1  EPC register load enable.
REQ-012 vec_read  out  1  request memory read at vec_addr; vec_addr  out  32  vector address.
REQ-013 exc_cause  out  2  latched cause of last accepted exception.
REQ-014 state  out  3  current FSM state, for debug.

Function
REQ-015 FSM states SHALL be FETCH, DECODE, RESOLVE, EXC_SAVE, EXC_VEC, EXC_LOAD.
REQ-016 FETCH: pcsrc_sel=000; pc_write=1 only in the cycle mem_ready=1, then go to DECODE; otherwise hold FETCH.
REQ-017 DECODE: hold until instr_valid=1; then go to RESOLVE, or to EXC_SAVE if exc_req!=00 or instr_class=7.
REQ-018 instr_class=7 SHALL be accepted as cause 10 (invalid opcode).
REQ-019 RESOLVE, exc_req=00: one cycle, then FETCH; pc_write and pcsrc_sel per REQ-020..023.
REQ-020 BEQ taken iff alu_zero=1; BNE iff alu_zero=0; BLE iff alu_gt=0; BGT iff alu_gt=1; taken -> pc_write=1, pcsrc_sel=001.
REQ-021 JUMP -> pc_write=1, pcsrc_sel=010; RTE -> pc_write=1, pcsrc_sel=011.
REQ-022 SEQ or untaken branch -> pc_write=0.
REQ-023 RESOLVE with exc_req!=00: exception wins; pc_write=0; go to EXC_SAVE.
REQ-024 On entry to EXC_SAVE, exc_cause SHALL latch the cause.
REQ-025 EXC_SAVE: epc_write=1 for exactly one cycle, then EXC_VEC.
REQ-026 EXC_VEC: vec_read=1; vec_addr=253 invalid opcode, 254 overflow, 255 divide by zero; hold until mem_ready=1, then EXC_LOAD.
REQ-027 EXC_LOAD: pc_write=1, pcsrc_sel=100 for one cycle, then FETCH.
REQ-028 exc_req SHALL be ignored in FETCH, EXC_SAVE, EXC_VEC and EXC_LOAD; nested exceptions are dropped.
REQ-029 When pc_write=0, pcsrc_sel SHALL still be driven with the state default (000); it shall never be X.
REQ-030 pc_write and epc_write SHALL never be asserted in the same cycle.
REQ-031 Outputs SHALL be Moore-style except the mem_ready gating of pc_write in FETCH.

Reset
REQ-032 reset_n=0 SHALL force state=FETCH, exc_cause=00, pc_write=0, epc_write=0, vec_read=0, pcsrc_sel=000, vec_addr=0, asynchronously.
REQ-033 Reset asserted mid-exception SHALL abandon the sequence; EPC contents are not restored.

Structure
REQ-034 Package pc_seq_pkg SHALL hold the state enum, instr_class enum, pcsrc_sel encodings and vector addresses 253/254/255.
REQ-035 Combinational sub-module pc_branch_cond SHALL compute taken from instr_class, alu_zero and alu_gt.

Verification
REQ-036 Reset, then mem_ready=1 -> FETCH pc_write=1 sel=000; DECODE; SEQ -> RESOLVE pc_write=0; back to FETCH in 3 cycles.
REQ-037 BEQ, alu_zero=1 -> RESOLVE pc_write=1 sel=001; BEQ, alu_zero=0 -> pc_write=0; BGT, alu_gt=1 -> sel=001.
REQ-038 Test 1: JUMP -> RESOLVE sel=010 pc_write=1. Test 2: RTE -> sel=011.
REQ-039 Overflow in RESOLVE during a taken BNE -> pc_write=0 that cycle; EXC_SAVE epc_write=1; EXC_VEC vec_addr=254; mem_ready delayed 4 cycles -> vec_read held 4 cycles; EXC_LOAD sel=100 pc_write=1; exc_cause=01.
REQ-040 instr_class=7 in DECODE -> EXC_SAVE, vec_addr=253, exc_cause=10; exc_req=11 asserted during EXC_VEC -> ignored.
REQ-041 reset_n pulsed low in EXC_VEC -> all outputs zero immediately; FETCH on release.
